// File: rtl/dmem_line_responder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_line_responder_pkg : shared widths and FSM encodings, rev 1.0    |
// +-----------------------------------------------------------------------+
package dmem_line_responder_pkg;

  localparam int c_REG_LEN      = 32;
  localparam int c_DM_LINE_W    = 256;
  localparam int c_DM_BYTE_UNIT = 5;
  localparam int c_DM_IDX_W     = 9;
  localparam int c_DM_LATENCY   = 10;

  typedef enum logic [1:0] {
    DM_IDLE = 2'h0,
    DM_BUSY = 2'h1,
    DM_ACK  = 2'h2
  } dm_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_line_array.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_line_array : single-port sync RAM, registered read, rev 1.0      |
// +-----------------------------------------------------------------------+
module dmem_line_array #(
  parameter int LINE_W = 256,
  parameter int IDX_W  = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] r_mem [2**IDX_W];

  // Read-first: a write edge returns the old line on rdata.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[addr] <= wdata;
    end
    rdata <= r_mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_line_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_line_responder : fixed-latency line memory responder, rev 1.0    |
// +-----------------------------------------------------------------------+
module dmem_line_responder
  import dmem_line_responder_pkg::*;
#(
  parameter int ADDR_W  = c_REG_LEN,
  parameter int LINE_W  = c_DM_LINE_W,
  parameter int OFFS_W  = c_DM_BYTE_UNIT,
  parameter int IDX_W   = c_DM_IDX_W,
  parameter int LATENCY = c_DM_LATENCY
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam logic [7:0] c_CNT_INIT = 8'(LATENCY - 1);

  dm_state_t         r_state;
  logic [7:0]        r_cnt;
  logic              r_ack;
  logic              r_rd_ack;
  logic [LINE_W-1:0] r_data_hold;
  logic [IDX_W-1:0]  r_idx;
  logic              r_write;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] w_rdata;
  logic              w_accept;
  logic              w_we;
  logic              w_unused_addr;

  assign w_accept      = (r_state == DM_IDLE) && enable_i;
  assign w_we          = (r_state == DM_BUSY) && (r_cnt == 8'd0) && r_write;
  assign w_unused_addr = ^{addr_i[ADDR_W-1:OFFS_W+IDX_W], addr_i[OFFS_W-1:0]};

  // Request latches are pure datapath and need no reset.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_idx   <= addr_i[OFFS_W+IDX_W-1:OFFS_W];
      r_write <= write_i;
      r_wdata <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= DM_IDLE;
      r_cnt       <= 8'd0;
      r_ack       <= 1'b0;
      r_rd_ack    <= 1'b0;
      r_data_hold <= '0;
    end else begin
      case (r_state)
        DM_IDLE: begin
          if (enable_i) begin
            r_cnt   <= c_CNT_INIT;
            r_state <= DM_BUSY;
          end
        end
        DM_BUSY: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_state  <= DM_ACK;
            r_ack    <= 1'b1;
            r_rd_ack <= !r_write;
          end
        end
        DM_ACK: begin
          // The RAM output moves on after this edge, so keep a copy.
          if (r_rd_ack) begin
            r_data_hold <= w_rdata;
          end
          r_ack    <= 1'b0;
          r_rd_ack <= 1'b0;
          r_state  <= DM_IDLE;
        end
        default: begin
          r_state <= DM_IDLE;
        end
      endcase
    end
  end

  dmem_line_array #(
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (clk_i),
    .we    (w_we),
    .addr  (r_idx),
    .wdata (r_wdata),
    .rdata (w_rdata)
  );

  assign ack_o  = r_ack;
  assign data_o = r_rd_ack ? w_rdata : r_data_hold;

endmodule
`default_nettype wire

// File: tb/tb_dmem_line_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dmem_line_responder : scoreboard bench, LATENCY 10 and 1, rev 1.0  |
// +-----------------------------------------------------------------------+
module tb_dmem_line_responder;

  typedef struct {
    int         cyc;
    bit         rd;
    logic [255:0] data;
  } exp_t;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  r_addr_a, r_addr_b;
  logic [255:0] r_data_a, r_data_b;
  logic         r_en_a, r_en_b, r_wr_a, r_wr_b;
  logic         w_ack_a, w_ack_b;
  logic [255:0] w_dout_a, w_dout_b;

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  bit           mon_on   = 0;
  bit           prev_a   = 0;
  bit           prev_b   = 0;
  logic [255:0] last_a   = '0;
  logic [255:0] last_b   = '0;
  exp_t         qa[$];
  exp_t         qb[$];
  exp_t         ea, eb;
  logic [255:0] mem_a [int];
  logic [255:0] mem_b [int];

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  dmem_line_responder #(.LATENCY(10)) dut_a (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (r_addr_a),
    .data_i   (r_data_a),
    .enable_i (r_en_a),
    .write_i  (r_wr_a),
    .ack_o    (w_ack_a),
    .data_o   (w_dout_a)
  );

  dmem_line_responder #(.LATENCY(1)) dut_b (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .addr_i   (r_addr_b),
    .data_i   (r_data_b),
    .enable_i (r_en_b),
    .write_i  (r_wr_b),
    .ack_o    (w_ack_b),
    .data_o   (w_dout_b)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every ack must match a queued expectation.
  always @(negedge clk_i) begin
    if (mon_on) begin
      if (w_ack_a) begin
        chk("a_ack_width", 256'(prev_a), 256'd0);
        if (qa.size() == 0) begin
          n_checks++; n_fail++;
          $error("FAIL a_unexpected_ack observed=1 expected=0");
        end else begin
          ea = qa.pop_front();
          chk("a_ack_cycle", 256'(cyc), 256'(ea.cyc));
          if (ea.rd) begin
            chk("a_rdata", w_dout_a, ea.data);
            last_a = ea.data;
          end else chk("a_data_hold", w_dout_a, last_a);
        end
      end else chk("a_data_hold", w_dout_a, last_a);
      prev_a = w_ack_a;

      if (w_ack_b) begin
        chk("b_ack_width", 256'(prev_b), 256'd0);
        if (qb.size() == 0) begin
          n_checks++; n_fail++;
          $error("FAIL b_unexpected_ack observed=1 expected=0");
        end else begin
          eb = qb.pop_front();
          chk("b_ack_cycle", 256'(cyc), 256'(eb.cyc));
          if (eb.rd) begin
            chk("b_rdata", w_dout_b, eb.data);
            last_b = eb.data;
          end else chk("b_data_hold", w_dout_b, last_b);
        end
      end else chk("b_data_hold", w_dout_b, last_b);
      prev_b = w_ack_b;
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the ack cycle.
  task automatic req(input int k, input logic [31:0] a, input bit wr,
                     input logic [255:0] d, input bit hold);
    exp_t e;
    int   idx;
    int   pending;
    idx   = int'(a[13:5]);
    e.rd  = !wr;
    e.cyc = cyc + 1 + ((k == 0) ? 10 : 1);
    e.data = '0;
    if (k == 0) begin
      r_addr_a = a; r_wr_a = wr; r_data_a = d; r_en_a = 1'b1;
      if (wr) mem_a[idx] = d; else e.data = mem_a[idx];
      qa.push_back(e);
    end else begin
      r_addr_b = a; r_wr_b = wr; r_data_b = d; r_en_b = 1'b1;
      if (wr) mem_b[idx] = d; else e.data = mem_b[idx];
      qb.push_back(e);
    end
    @(posedge clk_i) #1;
    if (!hold) begin
      if (k == 0) r_en_a = 1'b0; else r_en_b = 1'b0;
    end
    pending = (k == 0) ? qa.size() : qb.size();
    for (int i = 0; i < 100 && pending != 0; i++) begin
      @(posedge clk_i) #1;
      pending = (k == 0) ? qa.size() : qb.size();
    end
    if (pending != 0) begin
      n_checks++; n_fail++;
      $error("FAIL timeout_%0d observed=no_ack expected=ack", k);
      if (k == 0) qa.delete(); else qb.delete();
    end
  endtask

  initial begin
    #500000;
    $error("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [255:0] p_a5, p_r, p_w, p_x, p_p, p_y;
    p_a5 = {32{8'hA5}};
    p_r  = {8{32'h0BAD_F00D}};
    p_w  = {8{32'h1234_5678}};
    p_x  = {16{16'hC3C3}};
    p_p  = {4{64'hDEAD_BEEF_0000_1111}};
    p_y  = {8{32'h5A5A_0FF0}};
    rst_i = 1'b0;
    r_en_a = 1'b0; r_wr_a = 1'b0; r_addr_a = '0; r_data_a = '0;
    r_en_b = 1'b0; r_wr_b = 1'b0; r_addr_b = '0; r_data_b = '0;

    // Reset then idle: monitor checks ack/data_o every cycle.
    @(posedge clk_i) #1;
    mon_on = 1;
    repeat (2) @(posedge clk_i) #1;
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i) #1;

    // Write then read, LATENCY 10.
    req(0, 32'h0000_0040, 1'b1, p_a5, 1'b0);
    req(0, 32'h0000_0040, 1'b0, '0, 1'b0);

    // Write-back then refill with enable held through the ack edge.
    req(0, 32'h0000_0800, 1'b1, p_r, 1'b0);
    req(0, 32'h0000_0400, 1'b1, p_w, 1'b1);
    req(0, 32'h0000_0800, 1'b0, '0, 1'b0);
    req(0, 32'h0000_0400, 1'b0, '0, 1'b0);

    // Offset and upper-bit aliasing.
    req(0, 32'h0000_005F, 1'b1, p_x, 1'b0);
    req(0, 32'h0000_4040, 1'b0, '0, 1'b0);

    // Reset while BUSY with cnt = 4: write must not land, no ack.
    req(0, 32'h0000_0080, 1'b1, p_p, 1'b0);
    r_addr_a = 32'h0000_0080; r_wr_a = 1'b1; r_data_a = ~p_p; r_en_a = 1'b1;
    @(posedge clk_i) #1;
    r_en_a = 1'b0;
    repeat (5) @(posedge clk_i) #1;
    rst_i = 1'b0;
    last_a = '0;
    last_b = '0;
    repeat (2) @(posedge clk_i) #1;
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i) #1;
    req(0, 32'h0000_0080, 1'b0, '0, 1'b0);

    // LATENCY 1 with enable high only for the accept cycle.
    req(1, 32'h0000_0020, 1'b1, p_y, 1'b0);
    req(1, 32'h0000_0020, 1'b0, '0, 1'b0);
    req(1, 32'h3FFF_FFE0, 1'b1, p_r, 1'b0);
    req(1, 32'h0000_3FE0, 1'b0, '0, 1'b0);
    req(1, 32'h0000_0020, 1'b0, '0, 1'b0);

    repeat (5) @(posedge clk_i) #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
